// File: rtl/wb4_to_pi1.sv
// Wishbone B4 pipelined slave to PI1 master bridge; one single-beat transaction in flight.
// Optional response watchdog enabled by defining WB4_TO_PI1_TIMEOUT_EN.
module wb4_to_pi1 #(
  parameter int unsigned ARCHBITSZ = 32,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       wb4_cyc_i,
  input  logic                                       wb4_stb_i,
  input  logic                                       wb4_we_i,
  input  logic [ARCHBITSZ-1:0]                       wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]                       wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0]                     wb4_sel_i,
  output logic                                       wb4_stall_o,
  output logic                                       wb4_ack_o,
  output logic                                       wb4_err_o,
  output logic [ARCHBITSZ-1:0]                       wb4_data_o,
  output logic [1:0]                                 pi1_op_o,
  output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]                       pi1_data_o,
  input  logic [ARCHBITSZ-1:0]                       pi1_data_i,
  output logic [ARCHBITSZ/8-1:0]                     pi1_sel_o,
  input  logic                                       pi1_rdy_i
);

  localparam int unsigned AddrLsb = $clog2(ARCHBITSZ / 8);
  localparam logic [1:0] OpNoop = 2'd0;
  localparam logic [1:0] OpWr   = 2'd1;
  localparam logic [1:0] OpRd   = 2'd2;

  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

  state_e state;
  logic   we;
  logic   live;  // cleared if the initiator abandons the cycle; suppresses the ack

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^wb4_addr_i[AddrLsb-1:0];

`ifdef WB4_TO_PI1_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt;
`else
  assign wb4_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= StIdle;
      we          <= 1'b0;
      live        <= 1'b0;
      wb4_stall_o <= 1'b0;
      wb4_ack_o   <= 1'b0;
      wb4_data_o  <= '0;
      pi1_op_o    <= OpNoop;
      pi1_addr_o  <= '0;
      pi1_data_o  <= '0;
      pi1_sel_o   <= '0;
`ifdef WB4_TO_PI1_TIMEOUT_EN
      wb4_err_o   <= 1'b0;
      cnt         <= '0;
`endif
    end else begin
      wb4_ack_o <= 1'b0;
      if (state != StIdle && !wb4_cyc_i) live <= 1'b0;
      unique case (state)
        StIdle: begin
          if (wb4_cyc_i && wb4_stb_i) begin
            we          <= wb4_we_i;
            live        <= 1'b1;
            pi1_addr_o  <= wb4_addr_i[ARCHBITSZ-1:AddrLsb];
            pi1_data_o  <= wb4_data_i;
            pi1_sel_o   <= wb4_sel_i;
            pi1_op_o    <= wb4_we_i ? OpWr : OpRd;
            wb4_stall_o <= 1'b1;
            state       <= StReq;
          end
        end
        StReq: begin
          if (pi1_rdy_i) begin
            pi1_op_o <= OpNoop;
            state    <= StRsp;
          end
        end
        StRsp: begin
          // The PI1 side always completes, even when the Wishbone cycle was dropped.
          if (pi1_rdy_i) begin
            if (!we) wb4_data_o <= pi1_data_i;
            wb4_ack_o   <= live && wb4_cyc_i;
            wb4_stall_o <= 1'b0;
            state       <= StIdle;
          end
        end
        default: begin
          pi1_op_o    <= OpNoop;
          wb4_stall_o <= 1'b0;
          state       <= StIdle;
        end
      endcase
`ifdef WB4_TO_PI1_TIMEOUT_EN
      wb4_err_o <= 1'b0;
      if (state == StIdle) begin
        cnt <= '0;
      end else if (!(state == StRsp && pi1_rdy_i)) begin
        if (cnt == CntW'(TIMEOUT - 1)) begin
          pi1_op_o    <= OpNoop;
          wb4_err_o   <= live && wb4_cyc_i;
          wb4_stall_o <= 1'b0;
          state       <= StIdle;
          cnt         <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_wb4_to_pi1.sv
// Randomized self-checking bench for wb4_to_pi1 against a transaction-level model.
module tb_wb4_to_pi1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, wb_we = 1'b0;
  logic [31:0] wb_addr = '0, wb_wdata = '0;
  logic [3:0]  wb_sel = '0;
  logic        stall, ack, err;
  logic [31:0] wb_rdata;
  logic [1:0]  op;
  logic [29:0] p_addr;
  logic [31:0] p_wdata;
  logic [31:0] p_rdata = '0;
  logic [3:0]  p_sel;
  logic        rdy = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  wb4_to_pi1 #(.ARCHBITSZ(32), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb4_cyc_i(cyc), .wb4_stb_i(stb), .wb4_we_i(wb_we), .wb4_addr_i(wb_addr),
    .wb4_data_i(wb_wdata), .wb4_sel_i(wb_sel), .wb4_stall_o(stall), .wb4_ack_o(ack),
    .wb4_err_o(err), .wb4_data_o(wb_rdata), .pi1_op_o(op), .pi1_addr_o(p_addr),
    .pi1_data_o(p_wdata), .pi1_data_i(p_rdata), .pi1_sel_o(p_sel), .pi1_rdy_i(rdy)
  );

  // One Wishbone transaction; PI1 slave waits rq cycles before accepting and rs before replying.
  // k counts falling edges after the accepting rising edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int rq, input int rs, input logic [31:0] rd,
                      input logic drop,
                      output int ack_k, output int ack_n, output int err_n, output int op_cyc,
                      output int op3, output int stall_bad, output logic [1:0] op_seen,
                      output logic [29:0] addr_seen, output logic [31:0] data_seen,
                      output logic [3:0] sel_seen);
    ack_k = -1; ack_n = 0; err_n = 0; op_cyc = 0; op3 = 0; stall_bad = 0;
    op_seen = '0; addr_seen = '0; data_seen = '0; sel_seen = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wb_we = w; wb_addr = a; wb_wdata = d; wb_sel = s; rdy = 1'b0;
    for (int k = 0; k <= rq + rs + 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        stb = 1'b0;
        op_seen = op; addr_seen = p_addr; data_seen = p_wdata; sel_seen = p_sel;
      end
      if (op != 2'd0) op_cyc++;
      if (op == 2'd3) op3++;
      if (ack) begin
        ack_n++;
        if (ack_k < 0) ack_k = k;
      end
      if (err) err_n++;
      if (k < rq + rs + 2 && !stall) stall_bad++;
      if (k == rq + rs + 2 && stall) stall_bad++;
      if (drop && k == rq + 1) cyc = 1'b0;
      rdy = (k == rq) || (k == rq + rs + 1);
      p_rdata = (k == rq + rs + 1) ? rd : $urandom;
    end
    cyc = 1'b0; rdy = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if (op !== 2'd0 || ack !== 1'b0 || err !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: op=%0d ack=%b err=%b stall=%b, want 0 0 0 0", op, ack, err, stall);
    end
    vectors++;
    if (wb_rdata !== 32'h0 || p_addr !== 30'h0 || p_wdata !== 32'h0 || p_sel !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h sel=%h, want zeros",
               wb_rdata, p_addr, p_wdata, p_sel);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write;
    int ak, an, en, oc, o3, sb;
    logic [1:0] os; logic [29:0] as; logic [31:0] ds; logic [3:0] ss;
    xfer(1'b1, 32'h1004, 32'hDEADBEEF, 4'hF, 0, 0, 32'h0, 1'b0,
         ak, an, en, oc, o3, sb, os, as, ds, ss);
    vectors++;
    if (os !== 2'd1 || as !== 30'h401 || ss !== 4'hF || ds !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_req: op=%0d addr=%h sel=%h data=%h, want 1 401 f deadbeef", os, as, ss, ds);
    end
    vectors++;
    if (ak !== 2 || an !== 1) begin
      miscompares++;
      $display("FAIL write_ack: ack at %0d count %0d, want at 2 count 1", ak, an);
    end
    vectors++;
    if (sb !== 0 || en !== 0 || o3 !== 0) begin
      miscompares++;
      $display("FAIL write_misc: stall_bad=%0d err=%0d op3=%0d, want 0 0 0", sb, en, o3);
    end
  endtask

  task automatic test_read_wait;
    int ak, an, en, oc, o3, sb;
    logic [1:0] os; logic [29:0] as; logic [31:0] ds; logic [3:0] ss;
    xfer(1'b0, 32'h20, $urandom, 4'hF, 0, 5, 32'h12345678, 1'b0,
         ak, an, en, oc, o3, sb, os, as, ds, ss);
    last_rd = 32'h12345678;
    vectors++;
    if (os !== 2'd2 || as !== 30'h8 || oc !== 1) begin
      miscompares++;
      $display("FAIL read_req: op=%0d addr=%h op_cycles=%0d, want 2 8 1", os, as, oc);
    end
    vectors++;
    if (ak !== 7 || an !== 1 || sb !== 0) begin
      miscompares++;
      $display("FAIL read_ack: ack at %0d count %0d stall_bad %0d, want 7 1 0", ak, an, sb);
    end
    vectors++;
    if (wb_rdata !== 32'h12345678) begin
      miscompares++;
      $display("FAIL read_data: got %h want 12345678", wb_rdata);
    end
  endtask

  task automatic test_random;
    int ak, an, en, oc, o3, sb, rq, rs;
    logic [1:0] os; logic [29:0] as; logic [31:0] ds; logic [3:0] ss;
    logic w; logic [31:0] a, d, rd; logic [3:0] s;
    for (int i = 0; i < 10; i++) begin
      w = (i == 0) ? 1'b1 : 1'($urandom);
      a = $urandom; d = $urandom; rd = $urandom;
      s = (i == 0) ? 4'h0 : 4'($urandom);
      rq = $urandom_range(0, 3); rs = $urandom_range(0, 3);
      xfer(w, a, d, s, rq, rs, rd, 1'b0, ak, an, en, oc, o3, sb, os, as, ds, ss);
      if (!w) last_rd = rd;
      vectors++;
      if (os !== (w ? 2'd1 : 2'd2) || as !== a[31:2] || ss !== s || (w && ds !== d)) begin
        miscompares++;
        $display("FAIL rand_req[%0d]: op=%0d addr=%h sel=%h data=%h, want %0d %h %h %h",
                 i, os, as, ss, ds, w ? 1 : 2, a[31:2], s, d);
      end
      vectors++;
      if (ak !== rq + rs + 2 || an !== 1 || oc !== rq + 1) begin
        miscompares++;
        $display("FAIL rand_timing[%0d]: ack at %0d count %0d op_cycles %0d, want %0d 1 %0d",
                 i, ak, an, oc, rq + rs + 2, rq + 1);
      end
      vectors++;
      if (sb !== 0 || en !== 0 || o3 !== 0 || wb_rdata !== last_rd) begin
        miscompares++;
        $display("FAIL rand_misc[%0d]: stall_bad=%0d err=%0d op3=%0d rdata=%h, want 0 0 0 %h",
                 i, sb, en, o3, wb_rdata, last_rd);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a0, a1, d0, rd;
    logic [8:0] ack_mask;
    a0 = $urandom; a1 = $urandom; d0 = $urandom; rd = $urandom;
    ack_mask = '0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wb_we = 1'b1; wb_addr = a0; wb_wdata = d0; wb_sel = 4'hF;
    rdy = 1'b1; p_rdata = rd;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (ack) ack_mask[k] = 1'b1;
      if (k == 0) begin
        vectors++;
        if (op !== 2'd1 || p_addr !== a0[31:2]) begin
          miscompares++;
          $display("FAIL b2b_first: op=%0d addr=%h, want 1 %h", op, p_addr, a0[31:2]);
        end
        wb_we = 1'b0; wb_addr = a1;
      end
      if (k == 2) begin
        vectors++;
        if (stall !== 1'b0) begin
          miscompares++;
          $display("FAIL b2b_stall: stall=%b during first ack, want 0", stall);
        end
      end
      if (k == 3) begin
        stb = 1'b0;
        vectors++;
        if (op !== 2'd2 || p_addr !== a1[31:2]) begin
          miscompares++;
          $display("FAIL b2b_second: op=%0d addr=%h, want 2 %h", op, p_addr, a1[31:2]);
        end
      end
    end
    cyc = 1'b0; rdy = 1'b0;
    last_rd = rd;
    vectors++;
    if (ack_mask !== 9'b000100100 || wb_rdata !== rd) begin
      miscompares++;
      $display("FAIL b2b_acks: mask=%b rdata=%h, want 000100100 %h", ack_mask, wb_rdata, rd);
    end
  endtask

  task automatic test_cyc_drop;
    int ak, an, en, oc, o3, sb;
    logic [1:0] os; logic [29:0] as; logic [31:0] ds; logic [3:0] ss;
    logic [31:0] d;
    d = $urandom;
    xfer(1'b1, $urandom, d, 4'hF, 0, 3, 32'h0, 1'b1, ak, an, en, oc, o3, sb, os, as, ds, ss);
    vectors++;
    if (an !== 0 || sb !== 0 || oc !== 1) begin
      miscompares++;
      $display("FAIL drop_noack: acks=%0d stall_bad=%0d op_cycles=%0d, want 0 0 1", an, sb, oc);
    end
    xfer(1'b1, 32'h40, d, 4'h3, 1, 1, 32'h0, 1'b0, ak, an, en, oc, o3, sb, os, as, ds, ss);
    vectors++;
    if (ak !== 4 || an !== 1 || as !== 30'h10 || ss !== 4'h3) begin
      miscompares++;
      $display("FAIL drop_next: ack at %0d count %0d addr %h sel %h, want 4 1 10 3", ak, an, as, ss);
    end
  endtask

  task automatic test_reset_mid;
    int ak, an, en, oc, o3, sb;
    logic [1:0] os; logic [29:0] as; logic [31:0] ds; logic [3:0] ss;
    logic [31:0] rd;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wb_we = 1'b0; wb_addr = $urandom; rdy = 1'b0;
    @(negedge clk);
    stb = 1'b0;
    vectors++;
    if (op !== 2'd2) begin
      miscompares++;
      $display("FAIL rst_pre: op=%0d, want 2", op);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (op !== 2'd0 || stall !== 1'b0 || ack !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: op=%0d stall=%b ack=%b err=%b, want 0 0 0 0", op, stall, ack, err);
    end
    @(negedge clk);
    rst = 1'b0; cyc = 1'b0;
    last_rd = '0;
    rd = $urandom;
    xfer(1'b0, 32'h100, 32'h0, 4'hF, 1, 1, rd, 1'b0, ak, an, en, oc, o3, sb, os, as, ds, ss);
    last_rd = rd;
    vectors++;
    if (ak !== 4 || an !== 1 || wb_rdata !== rd) begin
      miscompares++;
      $display("FAIL rst_after: ack at %0d count %0d rdata %h, want 4 1 %h", ak, an, wb_rdata, rd);
    end
  endtask

`ifdef WB4_TO_PI1_TIMEOUT_EN
  task automatic test_timeout;
    int err_k, err_n, ack_n;
    err_k = -1; err_n = 0; ack_n = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; wb_we = 1'b0; wb_addr = $urandom; rdy = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      stb = 1'b0;
      if (err) begin
        err_n++;
        if (err_k < 0) err_k = k;
        vectors++;
        if (op !== 2'd0) begin
          miscompares++;
          $display("FAIL timeout_op: op=%0d at err, want 0", op);
        end
      end
      if (ack) ack_n++;
    end
    cyc = 1'b0;
    vectors++;
    if (err_k !== 15 || err_n !== 1 || ack_n !== 0) begin
      miscompares++;
      $display("FAIL timeout_err: err at %0d count %0d acks %0d, want 15 1 0", err_k, err_n, ack_n);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_read_wait;
    test_random;
    test_back_to_back;
    test_cyc_drop;
    test_reset_mid;
`ifdef WB4_TO_PI1_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
